// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV M-extension multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } op_e;

    // Most negative two's-complement value for the given width.
    function automatic logic [63:0] min_val(input int unsigned xlen);
        return 64'(1) << (xlen - 1);
    endfunction

    // Bit 0 is mul and wins over everything else; bit 7 is remu.
    function automatic op_e decode_op(input logic [7:0] inst);
        if      (inst[0]) return OP_MUL;
        else if (inst[1]) return OP_MULH;
        else if (inst[2]) return OP_MULHSU;
        else if (inst[3]) return OP_MULHU;
        else if (inst[4]) return OP_DIV;
        else if (inst[5]) return OP_DIVU;
        else if (inst[6]) return OP_REM;
        else if (inst[7]) return OP_REMU;
        else              return OP_NONE;
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
module muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [XLEN:0]   trial;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        // The quotient register doubles as the dividend shifter; a set MSB of trial means borrow.
        trial  = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (kill_i) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            if (!trial[XLEN]) begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) busy_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o      = busy_q && (cnt_q == CW'(XLEN - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit_p.sv
// RV M-extension multiply/divide unit: pipelined multiplier plus iterative divider
// sharing one result register and a single IDLE/MUL/DIV/FIX control FSM.
module muldiv_unit_p #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            inst_mul_i,
    input  logic            inst_mulh_i,
    input  logic            inst_mulhsu_i,
    input  logic            inst_mulhu_i,
    input  logic            inst_div_i,
    input  logic            inst_divu_i,
    input  logic            inst_rem_i,
    input  logic            inst_remu_i,
    input  logic [XLEN-1:0] operand_ra_i,
    input  logic [XLEN-1:0] operand_rb_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] MIN_V = XLEN'(min_val(XLEN));

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      mul_cnt_q, mul_cnt_d;
    logic            ready_q, ready_d;

    logic [7:0]      inst_vec;
    op_e             dec_op;
    logic            accept, dec_is_mul, dec_signed, div_special_in, div_start;
    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0] mul_now, mul_final;
    logic [XLEN-1:0] dvd_mag, dvs_mag;
    logic            div_done;
    logic [XLEN-1:0] div_quo, div_rem, div_res;
    logic            q_signed, q_is_rem;

    assign inst_vec = {inst_remu_i, inst_rem_i, inst_divu_i, inst_div_i,
                       inst_mulhu_i, inst_mulhsu_i, inst_mulh_i, inst_mul_i};
    assign dec_op     = decode_op(inst_vec);
    assign stall_o    = (state_q != ST_IDLE);
    assign accept     = valid_i & (|inst_vec) & ~stall_o & ~flush_i;
    assign dec_is_mul = dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign dec_signed = (dec_op == OP_DIV) || (dec_op == OP_REM);

    // Sign-extending to 2*XLEN makes one unsigned multiply serve all three signedness modes.
    assign a_sgn   = (dec_op == OP_MULH || dec_op == OP_MULHSU) & operand_ra_i[XLEN-1];
    assign b_sgn   = (dec_op == OP_MULH) & operand_rb_i[XLEN-1];
    assign a_ext   = {{XLEN{a_sgn}}, operand_ra_i};
    assign b_ext   = {{XLEN{b_sgn}}, operand_rb_i};
    assign prod    = a_ext * b_ext;
    assign mul_now = (dec_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    generate
        if (MUL_LAT == 1) begin : g_lat1
            assign mul_final = mul_now;
        end else begin : g_pipe
            logic [XLEN-1:0] pipe_q [MUL_LAT-1];
            logic [XLEN-1:0] pipe_d [MUL_LAT-1];

            always_comb begin
                pipe_d[0] = (accept && dec_is_mul) ? mul_now : pipe_q[0];
                for (int i = 1; i < MUL_LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
                end else begin
                    for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_d[i];
                end
            end

            assign mul_final = pipe_q[MUL_LAT-2];
        end
    endgenerate

    assign dvd_mag = (dec_signed & operand_ra_i[XLEN-1]) ? -operand_ra_i : operand_ra_i;
    assign dvs_mag = (dec_signed & operand_rb_i[XLEN-1]) ? -operand_rb_i : operand_rb_i;
    assign div_special_in = (operand_rb_i == '0) ||
                            (dec_signed && operand_ra_i == MIN_V && operand_rb_i == '1);
    assign div_start = accept & ~dec_is_mul & ~div_special_in;

    muldiv_div_iter #(.XLEN(XLEN)) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .kill_i      (flush_i & stall_o),
        .dividend_i  (dvd_mag),
        .divisor_i   (dvs_mag),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign q_signed = (op_q == OP_DIV) || (op_q == OP_REM);
    assign q_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);

    always_comb begin
        div_res = '0;
        if (rb_q == '0) begin
            div_res = q_is_rem ? ra_q : '1;
        end else if (q_signed && ra_q == MIN_V && rb_q == '1) begin
            div_res = q_is_rem ? '0 : MIN_V;
        end else if (q_is_rem) begin
            div_res = (q_signed & ra_q[XLEN-1]) ? -div_rem : div_rem;
        end else begin
            div_res = (q_signed & (ra_q[XLEN-1] ^ rb_q[XLEN-1])) ? -div_quo : div_quo;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        mul_cnt_d = mul_cnt_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = dec_op;
                    ra_d = operand_ra_i;
                    rb_d = operand_rb_i;
                    if (dec_is_mul) begin
                        if (MUL_LAT == 1) begin
                            ready_d  = 1'b1;
                            result_d = mul_final;
                        end else begin
                            state_d   = ST_MUL;
                            mul_cnt_d = 3'd1;
                        end
                    end else begin
                        state_d = div_special_in ? ST_FIX : ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (mul_cnt_q == 3'(MUL_LAT - 1)) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b1;
                    result_d = mul_final;
                end else begin
                    mul_cnt_d = mul_cnt_q + 3'd1;
                end
            end
            ST_DIV: begin
                if (flush_i)       state_d = ST_IDLE;
                else if (div_done) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush_i) begin
                    ready_d  = 1'b1;
                    result_d = div_res;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NONE;
            ra_q      <= '0;
            rb_q      <= '0;
            mul_cnt_q <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            mul_cnt_q <= mul_cnt_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit_p.sv
// Directed bench for muldiv_unit_p (XLEN=32, MUL_LAT=2); inputs change and outputs
// are sampled on the falling edge, the DUT acts on the rising edge.
module tb_muldiv_unit_p;

    localparam logic [7:0] I_MUL    = 8'h01;
    localparam logic [7:0] I_MULH   = 8'h02;
    localparam logic [7:0] I_MULHSU = 8'h04;
    localparam logic [7:0] I_MULHU  = 8'h08;
    localparam logic [7:0] I_DIV    = 8'h10;
    localparam logic [7:0] I_DIVU   = 8'h20;
    localparam logic [7:0] I_REM    = 8'h40;
    localparam logic [7:0] I_REMU   = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  inst_v;
    logic [31:0] ra, rb;
    logic        flush;
    logic        stall_o, ready_o;
    logic [31:0] result_o;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] last;
    int cnt;

    always #5 clk = ~clk;

    muldiv_unit_p #(.XLEN(32), .MUL_LAT(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (valid),
        .inst_mul_i    (inst_v[0]),
        .inst_mulh_i   (inst_v[1]),
        .inst_mulhsu_i (inst_v[2]),
        .inst_mulhu_i  (inst_v[3]),
        .inst_div_i    (inst_v[4]),
        .inst_divu_i   (inst_v[5]),
        .inst_rem_i    (inst_v[6]),
        .inst_remu_i   (inst_v[7]),
        .operand_ra_i  (ra),
        .operand_rb_i  (rb),
        .flush_i       (flush),
        .stall_o       (stall_o),
        .ready_o       (ready_o),
        .result_o      (result_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
        valid  = 1'b1;
        inst_v = inst;
        ra     = a;
        rb     = b;
    endtask

    task automatic quiet();
        valid  = 1'b0;
        inst_v = 8'h00;
    endtask

    // Issue at the current falling edge (cycle T), expect the single ready pulse at T+lat.
    task automatic do_op(input string tag, input logic [7:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] exp);
        int early;
        issue(inst, a, b);
        #1 check({tag, "_stall_T"}, {63'd0, stall_o}, 64'd0);
        early = 0;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                quiet();
                check({tag, "_stall_T1"}, {63'd0, stall_o}, 64'd1);
            end
            if (ready_o !== 1'b0) early++;
        end
        check({tag, "_early_ready"}, 64'(early), 64'd0);
        @(negedge clk);
        check({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
        check({tag, "_result"}, {32'd0, result_o}, {32'd0, exp});
        last = exp;
    endtask

    task automatic gap(input string tag);
        @(negedge clk);
        check({tag, "_pulse_end"}, {63'd0, ready_o}, 64'd0);
        check({tag, "_hold"}, {32'd0, result_o}, {32'd0, last});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ra = '0; rb = '0;
        quiet();
        last = '0;
        repeat (2) @(negedge clk);
        check("rst_stall",  {63'd0, stall_o}, 64'd0);
        check("rst_ready",  {63'd0, ready_o}, 64'd0);
        check("rst_result", {32'd0, result_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("mul_7x6", I_MUL, 32'd7, 32'd6, 2, 32'd42);
        gap("mul_7x6");
        do_op("mulh_min", I_MULH, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
        gap("mulh_min");
        do_op("mulhu_max", I_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        gap("mulhu_max");
        do_op("mulhsu_neg", I_MULHSU, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF);
        gap("mulhsu_neg");
        do_op("prio_mul", I_MUL | I_DIV, 32'd7, 32'd6, 2, 32'd42);
        gap("prio_mul");

        do_op("div_m7_2", I_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
        gap("div_m7_2");
        do_op("rem_m7_2", I_REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
        gap("rem_m7_2");
        do_op("div_7_m2", I_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD);
        gap("div_7_m2");
        do_op("rem_7_m2", I_REM, 32'd7, 32'hFFFF_FFFE, 34, 32'd1);
        gap("rem_7_m2");
        do_op("divu_100_7", I_DIVU, 32'd100, 32'd7, 34, 32'd14);
        gap("divu_100_7");
        do_op("remu_100_7", I_REMU, 32'd100, 32'd7, 34, 32'd2);
        gap("remu_100_7");

        do_op("divu_by0", I_DIVU, 32'd9, 32'd0, 2, 32'hFFFF_FFFF);
        gap("divu_by0");
        do_op("remu_by0", I_REMU, 32'd5, 32'd0, 2, 32'd5);
        gap("remu_by0");
        do_op("rem_by0_neg", I_REM, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFB);
        gap("rem_by0_neg");
        do_op("div_ovf", I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000);
        gap("div_ovf");
        do_op("rem_ovf", I_REM, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'd0);
        gap("rem_ovf");

        // Back-to-back: second mul offered in the ready cycle of the first.
        do_op("b2b_first", I_MUL, 32'd7, 32'd6, 2, 32'd42);
        do_op("b2b_second", I_MUL, 32'd3, 32'd5, 2, 32'd15);
        gap("b2b_second");

        // Offer while busy is ignored; the divide still completes with its own result.
        issue(I_DIVU, 32'd100, 32'd7);
        cnt = 0;
        @(negedge clk); quiet();
        @(negedge clk); issue(I_MUL, 32'd7, 32'd6);
        if (ready_o !== 1'b0) cnt++;
        @(negedge clk); quiet();
        if (ready_o !== 1'b0) cnt++;
        for (int k = 4; k <= 33; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b0) cnt++;
        end
        check("stall_offer_early", 64'(cnt), 64'd0);
        @(negedge clk);
        check("stall_offer_ready", {63'd0, ready_o}, 64'd1);
        check("stall_offer_result", {32'd0, result_o}, 64'd14);
        last = 32'd14;
        gap("stall_offer");

        // Flush mid-divide at T+5, then a mul at T+6.
        issue(I_DIVU, 32'd100, 32'd7);
        cnt = 0;
        @(negedge clk); quiet();
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b0) cnt++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_stall", {63'd0, stall_o}, 64'd0);
        check("flush_no_ready", 64'(cnt) + {63'd0, ready_o}, 64'd0);
        check("flush_result_kept", {32'd0, result_o}, {32'd0, last});
        do_op("flush_mul", I_MUL, 32'd7, 32'd6, 2, 32'd42);
        cnt = 0;
        repeat (45) begin
            @(negedge clk);
            if (ready_o !== 1'b0) cnt++;
        end
        check("flush_killed_silent", 64'(cnt), 64'd0);

        // Flush while idle blocks the offer.
        issue(I_MUL, 32'd9, 32'd9);
        flush = 1'b1;
        @(negedge clk);
        quiet(); flush = 1'b0;
        check("idle_flush_stall", {63'd0, stall_o}, 64'd0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready_o !== 1'b0) cnt++;
        end
        check("idle_flush_no_ready", 64'(cnt), 64'd0);
        check("idle_flush_result", {32'd0, result_o}, {32'd0, last});

        // Reset in the middle of a divide.
        issue(I_DIV, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk); quiet();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_stall",  {63'd0, stall_o}, 64'd0);
        check("midrst_ready",  {63'd0, ready_o}, 64'd0);
        check("midrst_result", {32'd0, result_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (ready_o !== 1'b0) cnt++;
        end
        check("midrst_no_ready", 64'(cnt), 64'd0);
        check("midrst_result_after", {32'd0, result_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_unit_p.md
MULDIV_UNIT_P -- requirements
Module: muldiv_unit_p

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand/result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MUL_LAT, default 2, giving the multiply latency in cycles; legal range is 1..4.
REQ-003 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  an operation is offered this cycle.
REQ-006 inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i, inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i  input  1 each  RV M-extension opcode decode.
REQ-007 operand_ra_i, operand_rb_i  input  XLEN  rs1 and rs2 operands.
REQ-008 flush_i  input  1  kill the in-flight operation.
REQ-009 stall_o  output  1  busy; no new operation is accepted.
REQ-010 ready_o  output  1  one-cycle pulse; result_o is valid in that cycle.
REQ-011 result_o  output  XLEN  operation result.

Function
REQ-012 accept = valid_i & (any inst_*) & ~stall_o & ~flush_i; operands and opcode SHALL be registered on accept.
REQ-013 When more than one inst_* is set, decode priority SHALL be mul > mulh > mulhsu > mulhu > div > divu > rem > remu.
REQ-014 The FSM SHALL have states IDLE, MUL, DIV, FIX.
- IDLE -> MUL on an accepted mul-class op.
- IDLE -> DIV on an accepted div-class op.
- MUL -> IDLE after MUL_LAT cycles.
- DIV -> FIX after XLEN iterations.
- FIX -> IDLE after 1 cycle.
REQ-015 stall_o SHALL be (state != IDLE).
REQ-016 MUL timing: for an op accepted at cycle T, ready_o SHALL be 0 at cycles T..T+MUL_LAT-1 and 1 at T+MUL_LAT.
REQ-017 mul SHALL return the product [XLEN-1:0]. mulh, mulhsu and mulhu SHALL return the product [2XLEN-1:XLEN] with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-018 Division SHALL be restoring radix-2 on magnitudes, one quotient bit per cycle; the FIX state applies sign correction. ready_o SHALL assert at T+XLEN+2.
REQ-019 Divide by zero (rb==0): quotient SHALL be all-ones and remainder SHALL be ra, for both signed and unsigned ops. The op SHALL bypass iteration (IDLE->FIX) and assert ready_o at T+2.
REQ-020 Signed overflow (ra==MIN, rb==all-ones): div SHALL return MIN and rem SHALL return 0, via the same T+2 bypass.
REQ-021 Signed remainder SHALL take the sign of the dividend; the quotient SHALL truncate toward zero.
REQ-022 ready_o SHALL pulse for exactly one cycle, in which state is IDLE; a new op MAY be accepted in that same cycle (back-to-back).
REQ-023 result_o SHALL hold the last completed result until the next ready_o.
REQ-024 flush_i while busy SHALL return the FSM to IDLE next cycle. The killed op SHALL produce no ready_o, and result_o SHALL be unchanged.
REQ-025 flush_i in IDLE SHALL block accept in that cycle and have no other effect.
REQ-026 An offer made while stall_o=1 SHALL be ignored. Inputs SHALL NOT be sampled mid-operation.

Reset
REQ-027 While rst_i is high: state=IDLE, stall_o=0, ready_o=0, result_o=0, all datapath registers cleared.
REQ-028 Reset asserted mid-operation SHALL abandon the op with no later ready_o.

Structure
REQ-029 Package muldiv_pkg SHALL hold the FSM state enum, the opcode enum (8 ops plus a NONE value), and function min_val(XLEN).
REQ-030 Sub-module muldiv_div_iter (iterative divider core with start/done) SHALL be used; the multiplier SHALL be an inline MUL_LAT-deep pipeline.

Verification (XLEN=32, MUL_LAT=2)
REQ-031 mul ra=7, rb=6 at T -> ready_o=0 at T and T+1; ready_o=1 with result_o=42 at T+2.
REQ-032 mulh ra=0x80000000, rb=0x80000000 -> result_o=0x40000000. mulhu ra=0xFFFFFFFF, rb=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 div ra=-7, rb=2 -> -3 at T+34. rem with the same operands -> -1. divu ra=100, rb=7 -> 14.
REQ-034 Special cases, each ready at T+2:
- divu with rb=0 -> 0xFFFFFFFF.
- remu ra=5, rb=0 -> 5.
- div ra=0x80000000, rb=0xFFFFFFFF -> 0x80000000.
- rem with the same operands -> 0.
REQ-035 Start a div, assert flush_i at T+5 -> stall_o=0 at T+6, no ready_o ever; a mul accepted at T+6 -> 42-style result at T+8.
REQ-036 Assert rst_i mid-div -> all outputs 0 immediately; no ready_o after reset release. Also: mul completing at T+2 with a new mul accepted in that same cycle -> second ready_o at T+4.
